nes_frame_scanout: RTL

//  Reads a stored 256x240 frame of 6-bit NES palette indices from a synchronous frame-buffer RAM and

---
 rtl/nes_video_pkg.sv | 32 +++
 rtl/nes_video_timing.sv | 44 ++++
 rtl/nes_frame_scanout.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/nes_video_pkg.sv
// Shared NES video timing constants, scan-out FSM encodings and small helpers.
package nes_video_pkg;

  localparam int COORD_W   = 9;
  localparam int H_TOTAL   = 341;
  localparam int V_TOTAL   = 262;
  localparam int H_VISIBLE = 256;
  localparam int V_VISIBLE = 240;

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_LIM = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS_LIM = COORD_W'(V_VISIBLE);

  localparam logic [5:0] BORDER_COLOR = 6'h0F;

  // Scan-out FSM encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Frame-buffer word address: one 256-entry row per scanline
  function automatic logic [15:0] fb_index(input logic [7:0] line, input logic [7:0] col);
    return {line, col};
  endfunction

  // True when a coordinate falls inside the 256x240 picture
  function automatic logic in_visible(input logic [COORD_W-1:0] h, input logic [COORD_W-1:0] v);
    return (h < H_VIS_LIM) && (v < V_VIS_LIM);
  endfunction

endpackage

// File: rtl/nes_video_timing.sv
// Horizontal/vertical raster counters with clear, advance and end-of-frame flag.
module nes_video_timing
  import nes_video_pkg::*;
#(
  parameter logic [COORD_W-1:0] H_END = H_LAST,
  parameter logic [COORD_W-1:0] V_END = V_LAST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] v,
  output logic               last_tick
);

  // Raster position: h wraps into the next scanline, v wraps at end of frame
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (clear) begin
      h <= '0;
      v <= '0;
    end else if (advance) begin
      if (h == H_END) begin
        h <= '0;
        if (v == V_END) begin
          v <= '0;
        end else begin
          v <= v + 9'd1;
        end
      end else begin
        h <= h + 9'd1;
      end
    end
  end

  // Final position of the frame; the next advance leaves the raster
  always_comb begin
    last_tick = (h == H_END) && (v == V_END);
  end

endmodule

// File: rtl/nes_frame_scanout.sv
// Replays a stored 256x240 frame of palette indices as a PPU-style pixel stream.
// Stage A issues the frame-buffer read for the current raster position; stage B,
// one ce tick later, presents that position with its pixel colour.
module nes_frame_scanout
  import nes_video_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        fb_addr,
  output logic               fb_rd,
  input  logic [5:0]         fb_rdata,
  output logic [5:0]         color,
  output logic [COORD_W-1:0] cycle,
  output logic [COORD_W-1:0] scanline,
  output logic               pix_valid
);

  logic [1:0]         state;
  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               last_tick;
  logic               clear;
  logic               advance;
  logic               vis;

  // Stage A -> stage B pipeline registers
  logic               pend;
  logic [COORD_W-1:0] pend_h;
  logic [COORD_W-1:0] pend_v;
  logic               pend_vis;
  logic [5:0]         data_q;
  logic [5:0]         pixel_color;

  nes_video_timing #(
    .H_END (H_LAST),
    .V_END (V_LAST)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .advance   (advance),
    .h         (h),
    .v         (v),
    .last_tick (last_tick)
  );

  // Counter control and visibility of the position being issued
  always_comb begin
    clear   = (state == IDLE) && ce && start;
    advance = (state == SCAN) && ce;
    vis     = in_visible(h, v);
  end

  // Pending pixel colour; when ce is high every clk the read is still in
  // flight on the output clk, so the RAM data is taken straight from fb_rdata
  always_comb begin
    pixel_color = BORDER_COLOR;
    if (pend_vis) begin
      if (fb_rd) begin
        pixel_color = fb_rdata;
      end else begin
        pixel_color = data_q;
      end
    end else begin
      pixel_color = BORDER_COLOR;
    end
  end

  // Read data capture, independent of ce so sparse ce cannot lose it
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= 6'h00;
    end else if (fb_rd) begin
      data_q <= fb_rdata;
    end
  end

  // FSM, read-request stage and output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      fb_rd      <= 1'b0;
      fb_addr    <= 16'h0000;
      color      <= BORDER_COLOR;
      cycle      <= 9'd0;
      scanline   <= 9'd0;
      pix_valid  <= 1'b0;
      pend       <= 1'b0;
      pend_h     <= 9'd0;
      pend_v     <= 9'd0;
      pend_vis   <= 1'b0;
    end else begin
      fb_rd      <= 1'b0;
      frame_done <= 1'b0;
      if (ce) begin
        case (state)
          IDLE: begin
            pix_valid <= 1'b0;
            color     <= BORDER_COLOR;
            if (start) begin
              state <= SCAN;
              busy  <= 1'b1;
              pend  <= 1'b0;
            end
          end
          SCAN: begin
            if (pend) begin
              cycle     <= pend_h;
              scanline  <= pend_v;
              pix_valid <= pend_vis;
              color     <= pixel_color;
            end
            if (vis) begin
              fb_addr <= fb_index(v[7:0], h[7:0]);
              fb_rd   <= 1'b1;
            end
            pend_h   <= h;
            pend_v   <= v;
            pend_vis <= vis;
            pend     <= 1'b1;
            if (last_tick) begin
              state <= FLUSH;
            end
          end
          FLUSH: begin
            cycle      <= pend_h;
            scanline   <= pend_v;
            pix_valid  <= pend_vis;
            color      <= pixel_color;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            pend       <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            pend  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
